// File: rtl/wbuart_pkg.sv
// Shared definitions for the wbuart_fifo Wishbone UART: register map, STATUS/CTRL
// bit positions and the transmit-source tag latched at the start of each byte.
package wbuart_pkg;

  typedef enum logic [1:0] {
    WBUART_DATA    = 2'd0,
    WBUART_STATUS  = 2'd1,
    WBUART_CTRL    = 2'd2,
    WBUART_DIVISOR = 2'd3
  } wbuart_reg_e;

  localparam int unsigned STS_RX_COUNT_LSB = 0;
  localparam int unsigned STS_TX_COUNT_LSB = 8;
  localparam int unsigned STS_RX_EMPTY     = 16;
  localparam int unsigned STS_TX_FULL      = 17;
  localparam int unsigned STS_OVERRUN      = 18;
  localparam int unsigned STS_SLAVE_MODE   = 19;

  localparam int unsigned CTRL_SLAVE_MODE  = 0;
  localparam int unsigned CTRL_LOOPBACK    = 1;

  typedef enum logic {
    LOADER = 1'b0,
    FIFO   = 1'b1
  } tx_src_e;

  // A 2**8-deep FIFO can hold 256 bytes; the 8-bit STATUS field saturates.
  function automatic logic [7:0] sat8(input logic [8:0] count);
    return count[8] ? 8'hFF : count[7:0];
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver; no reset, so a frame in progress always completes.
// Emits a one-cycle o_stb with o_data when a frame with a valid stop bit ends.
module uart_rx #(
  parameter int unsigned I_CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200
) (
  input  logic       i_clk,
  input  logic       i_rx,
  output logic       o_stb,
  output logic [7:0] o_data
);

  localparam int unsigned DIV = I_CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  typedef logic [CW-1:0] cnt_t;

  logic       rx_meta_n;
  logic       rx_n;
  logic       busy;
  cnt_t       baud_cnt;
  cnt_t       target;
  logic [3:0] bit_idx;
  logic [7:0] shreg;

  // Synchroniser stores the inverted line so a power-up zero reads as idle.
  always_ff @(posedge i_clk) begin
    rx_meta_n <= ~i_rx;
    rx_n      <= rx_meta_n;
  end

  assign target = (bit_idx == 4'd0) ? cnt_t'(DIV / 2 - 1) : cnt_t'(DIV - 1);

  always_ff @(posedge i_clk) begin
    o_stb <= 1'b0;
    if (!busy) begin
      if (rx_n) begin
        busy     <= 1'b1;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end
    end else if (baud_cnt == target) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd0) begin
        if (!rx_n) busy <= 1'b0;
        else       bit_idx <= 4'd1;
      end else if (bit_idx <= 4'd8) begin
        shreg   <= {~rx_n, shreg[7:1]};
        bit_idx <= bit_idx + 4'd1;
      end else begin
        busy <= 1'b0;
        if (!rx_n) begin
          o_stb  <= 1'b1;
          o_data <= shreg;
        end
      end
    end else begin
      baud_cnt <= baud_cnt + cnt_t'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; no reset, so a byte in flight always completes.
// i_start is honoured only while o_busy is low.
module uart_tx #(
  parameter int unsigned I_CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200
) (
  input  logic       i_clk,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int unsigned DIV = I_CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  typedef logic [CW-1:0] cnt_t;

  logic       busy;
  cnt_t       baud_cnt;
  logic [3:0] bit_idx;
  logic [9:0] shreg;

  always_ff @(posedge i_clk) begin
    if (!busy) begin
      if (i_start) begin
        shreg    <= {1'b1, i_data, 1'b0};
        busy     <= 1'b1;
        bit_idx  <= '0;
        baud_cnt <= '0;
      end
    end else if (baud_cnt == cnt_t'(DIV - 1)) begin
      baud_cnt <= '0;
      shreg    <= {1'b1, shreg[9:1]};
      if (bit_idx == 4'd9) busy <= 1'b0;
      else                 bit_idx <= bit_idx + 4'd1;
    end else begin
      baud_cnt <= baud_cnt + cnt_t'(1);
    end
  end

  assign o_busy = busy;
  assign o_tx   = busy ? shreg[0] : 1'b1;

endmodule

// File: rtl/wbuart_sync_fifo.sv
// Single-clock byte FIFO of 2**DEPTH_LOG2 entries with occupancy count.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module wbuart_sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic [7:0]            i_data,
  input  logic                  i_pop,
  output logic [7:0]            o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   count_t;

  localparam count_t DEPTH = count_t'(1) << DEPTH_LOG2;

  logic [7:0] mem [2**DEPTH_LOG2];
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  count_t     count;
  logic       do_push;
  logic       do_pop;

  assign o_full  = (count == DEPTH);
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];

  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + count_t'(1);
        2'b01:   count <= count - count_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wbuart_fifo.sv
// Wishbone UART with RX/TX FIFOs and byte-safe line sharing with the ihex loader.
// Optional internal loopback (CTRL bit1) is built when WBUART_LOOPBACK_EN is defined.
module wbuart_fifo
  import wbuart_pkg::*;
#(
  parameter int unsigned I_CLOCK_FREQ  = 50_000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned TX_DEPTH_LOG2 = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rx,
  output logic        o_tx,
  output logic [7:0]  o_ldr_rx_data,
  output logic        o_ldr_rx_stb,
  input  logic [7:0]  i_ldr_tx_data,
  input  logic        i_ldr_tx_stb,
  output logic        o_ldr_tx_busy,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  output logic        o_rx_irq,
  output logic        o_tx_irq
);

  localparam logic [31:0] DIVISOR = 32'(I_CLOCK_FREQ / BAUD_RATE);

  logic                   wb_req, wb_rd, wb_wr;
  wbuart_reg_e            reg_sel;
  logic [31:0]            rd_val;
  logic                   slave_mode, loopback, overrun;
  logic                   rx_line, rx_stb, rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]             rx_data, rx_head;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic                   tx_line, tx_busy, tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]             tx_head;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic                   tx_start_q, tx_launch;
  logic [7:0]             tx_data_q;
  tx_src_e                next_src;
  logic                   unused_ok;

  assign unused_ok = ^{i_wb_sel, i_wb_addr[29:2], i_wb_data[31:19], i_wb_data[17:8]};

  assign wb_req  = i_wb_cyc & i_wb_stb;
  assign wb_rd   = wb_req & ~i_wb_we;
  assign wb_wr   = wb_req & i_wb_we;
  assign reg_sel = wbuart_reg_e'(i_wb_addr[1:0]);

  assign o_wb_stall = 1'b0;
  assign o_wb_err   = 1'b0;
  assign o_rx_irq   = ~rx_empty;
  assign o_tx_irq   = tx_empty;

  assign rx_pop  = wb_rd & (reg_sel == WBUART_DATA) & ~rx_empty;
  assign rx_push = rx_stb & slave_mode;
  assign tx_push = wb_wr & (reg_sel == WBUART_DATA);

  // Loader is held off while in slave mode and while software bytes drain.
  assign o_ldr_tx_busy = slave_mode | tx_busy | tx_start_q | ~tx_empty;

`ifdef WBUART_LOOPBACK_EN
  assign rx_line = loopback ? tx_line : i_rx;
  assign o_tx    = loopback ? 1'b1 : tx_line;
`else
  assign loopback = 1'b0;
  assign rx_line  = i_rx;
  assign o_tx     = tx_line;
`endif

  wbuart_sync_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_push(rx_push), .i_data(rx_data),
    .i_pop(rx_pop), .o_data(rx_head), .o_full(rx_full), .o_empty(rx_empty),
    .o_count(rx_count)
  );

  wbuart_sync_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_push(tx_push), .i_data(i_wb_data[7:0]),
    .i_pop(tx_pop), .o_data(tx_head), .o_full(tx_full), .o_empty(tx_empty),
    .o_count(tx_count)
  );

  uart_rx #(.I_CLOCK_FREQ(I_CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart_rx (
    .i_clk(i_clk), .i_rx(rx_line), .o_stb(rx_stb), .o_data(rx_data)
  );

  uart_tx #(.I_CLOCK_FREQ(I_CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart_tx (
    .i_clk(i_clk), .i_start(tx_start_q), .i_data(tx_data_q), .o_busy(tx_busy),
    .o_tx(tx_line)
  );

  // Source is chosen only when the line is idle; queued FIFO bytes go before loader bytes.
  always_comb begin
    tx_launch = 1'b0;
    tx_pop    = 1'b0;
    next_src  = FIFO;
    if (!tx_busy && !tx_start_q) begin
      if (!tx_empty) begin
        tx_launch = 1'b1;
        tx_pop    = 1'b1;
      end else if (!slave_mode && i_ldr_tx_stb) begin
        tx_launch = 1'b1;
        next_src  = LOADER;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      WBUART_DATA: if (!rx_empty) rd_val = {23'b0, 1'b1, rx_head};
      WBUART_STATUS: begin
        rd_val[STS_RX_COUNT_LSB +: 8] = sat8(9'(rx_count));
        rd_val[STS_TX_COUNT_LSB +: 8] = sat8(9'(tx_count));
        rd_val[STS_RX_EMPTY]          = rx_empty;
        rd_val[STS_TX_FULL]           = tx_full;
        rd_val[STS_OVERRUN]           = overrun;
        rd_val[STS_SLAVE_MODE]        = slave_mode;
      end
      WBUART_CTRL: begin
        rd_val[CTRL_SLAVE_MODE] = slave_mode;
        rd_val[CTRL_LOOPBACK]   = loopback;
      end
      WBUART_DIVISOR: rd_val = DIVISOR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack      <= 1'b0;
      o_wb_data     <= '0;
      o_ldr_rx_stb  <= 1'b0;
      o_ldr_rx_data <= '0;
      slave_mode    <= 1'b0;
      overrun       <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
`ifdef WBUART_LOOPBACK_EN
      loopback      <= 1'b0;
`endif
    end else begin
      o_wb_ack     <= wb_req;
      o_ldr_rx_stb <= 1'b0;
      tx_start_q   <= tx_launch;
      if (tx_launch) tx_data_q <= (next_src == FIFO) ? tx_head : i_ldr_tx_data;
      if (rx_stb && !slave_mode) begin
        o_ldr_rx_stb  <= 1'b1;
        o_ldr_rx_data <= rx_data;
      end
      if (wb_rd) o_wb_data <= rd_val;
      if (wb_wr) begin
        unique case (reg_sel)
          WBUART_DATA:   slave_mode <= 1'b1;
          WBUART_STATUS: if (i_wb_data[STS_OVERRUN]) overrun <= 1'b0;
          WBUART_CTRL: begin
            slave_mode <= i_wb_data[CTRL_SLAVE_MODE];
`ifdef WBUART_LOOPBACK_EN
            loopback   <= i_wb_data[CTRL_LOOPBACK];
`endif
          end
          WBUART_DIVISOR: ;
        endcase
      end
      if (rx_push && rx_full && !rx_pop) overrun <= 1'b1;
    end
  end

endmodule

// File: doc/wbuart_fifo.md
# wbuart_fifo

Parametrised Wishbone UART peripheral: next generation of the UART/Intel-HEX bridge. Adds RX and TX FIFOs of configurable depth, a CPU-visible register file, and explicit, byte-boundary-safe arbitration of the serial line between the external Intel-HEX loader and CPU software. Sits between the board UART pins, the `ihex` loader byte-stream ports, and the CPU data bus as a Wishbone slave.

## Interface
- `I_CLOCK_FREQ`, 50_000000: system clock in Hz.
- `BAUD_RATE`, 115200: line rate; fixed at elaboration.
- `RX_DEPTH_LOG2`, 4: RX FIFO holds 2**N bytes; legal range 1..8.
- `TX_DEPTH_LOG2`, 4: TX FIFO holds 2**N bytes; legal range 1..8.

Ports:
- `i_clk` in 1: system clock; the block's only clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_rx` in 1: serial in.
- `o_tx` out 1: serial out.
- `o_ldr_rx_data` out 8: received byte routed to the loader.
- `o_ldr_rx_stb` out 1: one-cycle strobe for `o_ldr_rx_data`.
- `i_ldr_tx_data` in 8: loader byte to transmit.
- `i_ldr_tx_stb` in 1: loader transmit request.
- `o_ldr_tx_busy` out 1: loader must hold its byte while high.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` in 1 each: Wishbone slave controls.
- `i_wb_sel` in 4: byte selects; ignored, full-word access.
- `i_wb_addr` in 30: word address; only bits [1:0] are decoded.
- `i_wb_data` in 32: write data.
- `o_wb_stall`, `o_wb_ack`, `o_wb_err` out 1 each: slave response.
- `o_wb_data` out 32: read data.
- `o_rx_irq` out 1: RX FIFO non-empty.
- `o_tx_irq` out 1: TX FIFO empty.

## Operation
- Registers, by `addr[1:0]`:
  - 0 DATA: read pops RX and returns `{23'b0, valid, byte}`; empty returns 0 with no pop. Write pushes `data[7:0]` to TX and sets `slave_mode`.
  - 1 STATUS: `[7:0]` rx_count, `[15:8]` tx_count, `[16]` rx_empty, `[17]` tx_full, `[18]` overrun (sticky), `[19]` slave_mode. Writing 1 to bit 18 clears overrun.
  - 2 CTRL: `[0]` slave_mode, `[1]` loopback (see Configuration). Read/write.
  - 3 DIVISOR: read-only, returns `I_CLOCK_FREQ/BAUD_RATE`. Writes are ignored.
- Loader mode (`slave_mode`=0):
  - RX bytes go to `o_ldr_*` only; the RX FIFO is not written.
  - TX source is `i_ldr_tx_*`. `o_ldr_tx_busy` = uart_tx busy OR the TX FIFO is still draining.
- Slave mode:
  - RX bytes go to the RX FIFO; `o_ldr_rx_stb` stays 0.
  - TX source is the TX FIFO head, popped when uart_tx is idle. `o_ldr_tx_busy`=1.
  - Left only by reset or by a CTRL write with bit0=0.
- Mode switch is byte-safe. The TX source is latched when each byte starts; an in-flight byte always completes. In loader mode the TX FIFO drains first, before loader bytes are taken.
- RX full with no pop: byte dropped, overrun set. Pop and push in the same cycle on a full FIFO: both happen, no overrun.
- TX full: write is acked and dropped. Software polls tx_full.

## Timing
- `o_wb_stall` is always 0. `o_wb_err` is always 0.
- `o_wb_ack` rises exactly one cycle after any `cyc&stb`, with registered `o_wb_data`.
- Pop and push effects are visible in STATUS on the next access.
- uart_rx strobe at cycle t:
  - FIFO count increments at t+1, or
  - `o_ldr_rx_stb` pulses at t+1.
- TX FIFO push at t: uart_tx start no earlier than t+2 when idle.
- Reset values: ack=0, `o_wb_data`=0, FIFOs empty, slave_mode=0, loopback=0, overrun=0, `o_rx_irq`=0, `o_tx_irq`=1, `o_ldr_rx_stb`=0, `o_tx`=1.
- Reset mid-byte:
  - uart_rx/uart_tx are unreset; the serial byte in flight finishes.
  - A completed RX byte is discarded while `i_reset_n`=0.
  - No new TX start occurs until 1 cycle after reset release.

## Configuration
- `WBUART_LOOPBACK_EN` defined:
  - CTRL bit1 is implemented.
  - When set, uart_tx output feeds uart_rx internally and `o_tx` is held at 1.
- Undefined: bit1 reads 0, writes are ignored, and `i_rx` is always used.

## Structure
- Shared package `wbuart_pkg`:
  - register address enum (`WBUART_DATA`/`STATUS`/`CTRL`/`DIVISOR`)
  - STATUS/CTRL bit-index constants
  - `tx_src_e` (LOADER, FIFO)
- Sub-module `wbuart_sync_fifo` (param `DEPTH_LOG2`, width 8), instantiated twice.
  - Ports: push, pop, full, empty, count (`DEPTH_LOG2+1` bits).
  - Pointers wrap at 2**N.
- Existing `uart_rx`/`uart_tx` are reused, parametrised by `I_CLOCK_FREQ`/`BAUD_RATE`.

## Test plan
- Reset, then loader mode. Serial byte 0x3A → single `o_ldr_rx_stb` with 0x3A; rx_count stays 0.
- Write DATA=0x55 → STATUS bit19=1. 0x55 appears on `o_tx`, followed by `o_tx_irq`=1.
- Slave mode, RX_DEPTH_LOG2=2: send 5 bytes, no reads → rx_count=4, overrun=1. Four DATA reads return bytes 1-4 with valid=1; the fifth read returns 0.
- Loader byte 0xA5 mid-transmission, CTRL write slave_mode=1 → 0xA5 completes intact; the next TX byte comes from the FIFO.
- With `WBUART_LOOPBACK_EN`: set CTRL=0x3, write DATA=0x81 → read DATA returns 0x181; `o_tx` stays 1 throughout.
- Assert `i_reset_n` with 3 bytes in the TX FIFO → after release STATUS=0x0001_0000; `o_tx` idles high after the current byte.
